// File: rtl/idu_reg_if.sv
// rtl/idu_reg_if.sv - IFU-facing and EXU-facing handshake bundle of the decode stage
// o_illegal exists only when IDU_ILLEGAL_TRAP_EN is defined.
interface idu_reg_if #(
    parameter int CPU_WIDTH     = 64,
    parameter int EXU_SEL_WIDTH = 2,
    parameter int EXU_OPT_WIDTH = 5
);
    logic                     i_flush;
    logic                     i_valid;
    logic                     o_ready;
    logic [31:0]              i_inst;
    logic [CPU_WIDTH-1:0]     i_pc;
    logic                     o_valid;
    logic                     i_ready;
    logic [CPU_WIDTH-1:0]     o_pc;
    logic [4:0]               o_rs1_idx;
    logic [4:0]               o_rs2_idx;
    logic [4:0]               o_rd_idx;
    logic                     o_rd_wen;
    logic [CPU_WIDTH-1:0]     o_imm;
    logic [EXU_SEL_WIDTH-1:0] o_src_sel;
    logic [EXU_OPT_WIDTH-1:0] o_opt;
    logic                     o_branch;
    logic                     o_jal;
    logic                     o_jalr;
`ifdef IDU_ILLEGAL_TRAP_EN
    logic                     o_illegal;
`endif

    modport master (
`ifdef IDU_ILLEGAL_TRAP_EN
        input  o_illegal,
`endif
        output i_flush, i_valid, i_inst, i_pc, i_ready,
        input  o_ready, o_valid, o_pc, o_rs1_idx, o_rs2_idx, o_rd_idx, o_rd_wen,
        input  o_imm, o_src_sel, o_opt, o_branch, o_jal, o_jalr
    );

    modport slave (
`ifdef IDU_ILLEGAL_TRAP_EN
        output o_illegal,
`endif
        input  i_flush, i_valid, i_inst, i_pc, i_ready,
        output o_ready, o_valid, o_pc, o_rs1_idx, o_rs2_idx, o_rd_idx, o_rd_wen,
        output o_imm, o_src_sel, o_opt, o_branch, o_jal, o_jalr
    );
endinterface

// File: rtl/idu_reg.sv
// rtl/idu_reg.sv - RV64I decode with one-entry output register toward the EXU
// IDU_ILLEGAL_TRAP_EN: flag unsupported encodings on o_illegal instead of decoding them as NOP.
module idu_reg #(
    parameter int CPU_WIDTH     = 64,
    parameter int EXU_SEL_WIDTH = 2,
    parameter int EXU_OPT_WIDTH = 5
) (
    input  logic     i_clk,
    input  logic     i_rst,
    idu_reg_if.slave bus
);
    localparam logic [EXU_SEL_WIDTH-1:0] EXU_SEL_REG = 2'd0;
    localparam logic [EXU_SEL_WIDTH-1:0] EXU_SEL_IMM = 2'd1;
    localparam logic [EXU_SEL_WIDTH-1:0] EXU_SEL_PC4 = 2'd2;
    localparam logic [EXU_SEL_WIDTH-1:0] EXU_SEL_PCI = 2'd3;

    localparam logic [EXU_OPT_WIDTH-1:0] EXU_ADD  = 5'd0;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SUB  = 5'd1;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLL  = 5'd2;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLT  = 5'd3;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLTU = 5'd4;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_XOR  = 5'd5;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SRL  = 5'd6;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SRA  = 5'd7;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_OR   = 5'd8;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_AND  = 5'd9;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_BEQ  = 5'd10;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_BNE  = 5'd11;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_BLT  = 5'd12;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_BGE  = 5'd13;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_BLTU = 5'd14;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_BGEU = 5'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [CPU_WIDTH-1:0] imm_i, imm_u, imm_b, imm_j, imm_sh;

    assign inst   = bus.i_inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{(CPU_WIDTH-12){inst[31]}}, inst[31:20]};
    assign imm_u  = {{(CPU_WIDTH-32){inst[31]}}, inst[31:12], 12'b0};
    assign imm_b  = {{(CPU_WIDTH-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j  = {{(CPU_WIDTH-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = {{(CPU_WIDTH-6){1'b0}}, inst[25:20]};

    logic [4:0]               d_rs1, d_rs2, d_rd;
    logic                     d_wen, d_branch, d_jal, d_jalr, d_legal;
    logic [CPU_WIDTH-1:0]     d_imm;
    logic [EXU_SEL_WIDTH-1:0] d_sel;
    logic [EXU_OPT_WIDTH-1:0] d_opt;

    always_comb begin
        d_rs1    = 5'd0;
        d_rs2    = 5'd0;
        d_rd     = 5'd0;
        d_wen    = 1'b0;
        d_imm    = '0;
        d_sel    = EXU_SEL_REG;
        d_opt    = EXU_ADD;
        d_branch = 1'b0;
        d_jal    = 1'b0;
        d_jalr   = 1'b0;
        d_legal  = 1'b1;
        case (opcode)
            OPC_OP: begin
                d_rs1 = inst[19:15];
                d_rs2 = inst[24:20];
                d_rd  = inst[11:7];
                d_wen = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: d_opt = EXU_ADD;
                    {7'h20, 3'b000}: d_opt = EXU_SUB;
                    {7'h00, 3'b001}: d_opt = EXU_SLL;
                    {7'h00, 3'b010}: d_opt = EXU_SLT;
                    {7'h00, 3'b011}: d_opt = EXU_SLTU;
                    {7'h00, 3'b100}: d_opt = EXU_XOR;
                    {7'h00, 3'b101}: d_opt = EXU_SRL;
                    {7'h20, 3'b101}: d_opt = EXU_SRA;
                    {7'h00, 3'b110}: d_opt = EXU_OR;
                    {7'h00, 3'b111}: d_opt = EXU_AND;
                    default:         d_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                d_rs1 = inst[19:15];
                d_rd  = inst[11:7];
                d_wen = 1'b1;
                d_sel = EXU_SEL_IMM;
                d_imm = imm_i;
                case (funct3)
                    3'b000: d_opt = EXU_ADD;
                    3'b010: d_opt = EXU_SLT;
                    3'b011: d_opt = EXU_SLTU;
                    3'b100: d_opt = EXU_XOR;
                    3'b110: d_opt = EXU_OR;
                    3'b111: d_opt = EXU_AND;
                    3'b001: begin
                        d_opt   = EXU_SLL;
                        d_imm   = imm_sh;
                        d_legal = (inst[31:26] == 6'b000000);
                    end
                    default: begin
                        // RV64 shifts carry a 6-bit shamt, so only inst[30] may be set above it
                        d_opt   = inst[30] ? EXU_SRA : EXU_SRL;
                        d_imm   = imm_sh;
                        d_legal = ({inst[31], inst[29:26]} == 5'b00000);
                    end
                endcase
            end
            OPC_LUI: begin
                d_rd  = inst[11:7];
                d_wen = 1'b1;
                d_sel = EXU_SEL_IMM;
                d_imm = imm_u;
            end
            OPC_AUIPC: begin
                d_rd  = inst[11:7];
                d_wen = 1'b1;
                d_sel = EXU_SEL_PCI;
                d_imm = imm_u;
            end
            OPC_JAL: begin
                d_rd  = inst[11:7];
                d_wen = 1'b1;
                d_sel = EXU_SEL_PC4;
                d_imm = imm_j;
                d_jal = 1'b1;
            end
            OPC_JALR: begin
                d_rs1   = inst[19:15];
                d_rd    = inst[11:7];
                d_wen   = 1'b1;
                d_sel   = EXU_SEL_PC4;
                d_imm   = imm_i;
                d_jalr  = 1'b1;
                d_legal = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                d_rs1    = inst[19:15];
                d_rs2    = inst[24:20];
                d_imm    = imm_b;
                d_branch = 1'b1;
                case (funct3)
                    3'b000:  d_opt = EXU_BEQ;
                    3'b001:  d_opt = EXU_BNE;
                    3'b100:  d_opt = EXU_BLT;
                    3'b101:  d_opt = EXU_BGE;
                    3'b110:  d_opt = EXU_BLTU;
                    3'b111:  d_opt = EXU_BGEU;
                    default: d_legal = 1'b0;
                endcase
            end
            default: d_legal = 1'b0;
        endcase
        if (!d_legal) begin
            d_rs1    = 5'd0;
            d_rs2    = 5'd0;
            d_rd     = 5'd0;
            d_wen    = 1'b0;
            d_imm    = '0;
            d_sel    = EXU_SEL_REG;
            d_opt    = EXU_ADD;
            d_branch = 1'b0;
            d_jal    = 1'b0;
            d_jalr   = 1'b0;
        end
        if (d_rd == 5'd0) begin
            d_wen = 1'b0;
        end
    end

    logic load;
    assign bus.o_ready = ~bus.o_valid | bus.i_ready;
    assign load        = bus.i_valid & bus.o_ready & ~bus.i_flush;

    // Valid follows flush > load > drain; bundle fields change only on load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_valid <= 1'b0;
        end else if (bus.i_flush) begin
            bus.o_valid <= 1'b0;
        end else if (load) begin
            bus.o_valid <= 1'b1;
        end else if (bus.i_ready) begin
            bus.o_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_pc      <= '0;
            bus.o_rs1_idx <= 5'd0;
            bus.o_rs2_idx <= 5'd0;
            bus.o_rd_idx  <= 5'd0;
            bus.o_rd_wen  <= 1'b0;
            bus.o_imm     <= '0;
            bus.o_src_sel <= EXU_SEL_REG;
            bus.o_opt     <= EXU_ADD;
            bus.o_branch  <= 1'b0;
            bus.o_jal     <= 1'b0;
            bus.o_jalr    <= 1'b0;
`ifdef IDU_ILLEGAL_TRAP_EN
            bus.o_illegal <= 1'b0;
`endif
        end else if (load) begin
            bus.o_pc      <= bus.i_pc;
            bus.o_rs1_idx <= d_rs1;
            bus.o_rs2_idx <= d_rs2;
            bus.o_rd_idx  <= d_rd;
            bus.o_rd_wen  <= d_wen;
            bus.o_imm     <= d_imm;
            bus.o_src_sel <= d_sel;
            bus.o_opt     <= d_opt;
            bus.o_branch  <= d_branch;
            bus.o_jal     <= d_jal;
            bus.o_jalr    <= d_jalr;
`ifdef IDU_ILLEGAL_TRAP_EN
            bus.o_illegal <= ~d_legal;
`endif
        end
    end
endmodule
